arf132b256e1r1w0cbbehcaa4acw_wr_stage: RTL and testbench
========================================================

Name: arf132b256e1r1w0cbbehcaa4acw_wr_stage

Overview:
Write-port front end for the 132b x 256-entry 1R1W latch array. It accepts write requests over a valid/ready handshake and buffers them in a 2-entry skid buffer. On the rising clock edge it issues one write into flops: a one-hot word enable plus data, held stable for the whole cycle. Those flops feed the phase-B data latches, which are transparent while the clock is low. It also provides same-cycle read-after-write bypass information and a saturating count of issued writes.

Parameters:
DWIDTH, 132, write data width
NUM_ENTRIES, 256, number of array words
ADR_W, 8, address width; must satisfy NUM_ENTRIES <= 2**ADR_W
CNT_W, 16, width of the issued-write counter

Ports:
clk  input  1  array clock; all flops rise-edge
rst_n  input  1  asynchronous active-low reset
wr_vld  input  1  write request valid
wr_rdy  output  1  stage can accept a request
wr_adr  input  ADR_W  write address
wr_data  input  DWIDTH  write data
array_hold  input  1  array write-inhibit (power/test); stalls issue
wen_q  output  NUM_ENTRIES  one-hot registered word enable to latch array
wdata_q  output  DWIDTH  registered write data to phase-B latches
rd_adr  input  ADR_W  read address of the concurrent read port
byp_hit  output  1  rd_adr matches the word being written this cycle
byp_data  output  DWIDTH  equals wdata_q; valid when byp_hit
err_oor  output  1  one-cycle pulse: accepted request dropped, address >= NUM_ENTRIES
wr_cnt  output  CNT_W  issued-write count, saturating

Behaviour:
- Reset (async assert, sync release via flops): buffer count=0, wen_q=0, wdata_q=0, issued address reg=0, err_oor=0, wr_cnt=0. wr_rdy=0 while rst_n=0, then 1.
- Accept: a request is accepted when wr_vld & wr_rdy. wr_rdy = (count<2), from registered count only; no combinational path from wr_vld or array_hold.
- Issue source: buffer head if count>0, else the incoming accepted request (flow-through). Issue occurs when a source exists and array_hold=0.
- Issue edge: wen_q <= onehot(adr), wdata_q <= data, issued address reg <= adr, wr_cnt += 1 (saturates at all-ones).
- Latency: with an empty buffer and no hold, a request accepted in cycle N has wen_q active in cycle N+1.
- Idle cycle (no issue): wen_q <= 0; wdata_q holds its previous value, so no data toggle reaches the latches.
- Ordering: strict FIFO. Back-to-back writes to the same address both issue in order; the last one wins.
- Simultaneous accept+issue with count=2 is impossible (wr_rdy=0). With count=1, pop head and push new; count stays 1.
- array_hold: requests keep being accepted until count=2; wen_q=0 for every held cycle. After deassertion, issue resumes from the head on the next edge.
- Out-of-range (adr >= NUM_ENTRIES; only possible when NUM_ENTRIES < 2**ADR_W): checked at accept. The request is not buffered and not issued; err_oor=1 in the following cycle. wr_cnt is unchanged.
- Bypass: byp_hit = |wen_q & (rd_adr == issued address reg); byp_data = wdata_q. Both are combinational from flops plus rd_adr. byp_hit=0 whenever wen_q=0.
- Reset mid-operation: buffered requests are discarded and wen_q drops to 0 asynchronously.
- Assertions: $onehot0(wen_q); count <= 2; wr_data and wr_adr stable while wr_vld & ~wr_rdy.

Decomposition:
- Shared package arf132b256e1r1w0cbbehcaa4acw_pkg: DWIDTH, NUM_ENTRIES, ADR_W constants; typedef wr_req_t {adr, data}.
- Sub-module arf132b256e1r1w0cbbehcaa4acw_skid2: generic 2-entry valid/ready skid buffer of wr_req_t, with count and head outputs. Decode, issue flops, bypass compare and counter stay in the top.

Test Plan:
- Reset then a single write adr=0x05, data=0xA5..A5 with no hold -> wen_q bit 5 only in the next cycle; wdata_q=0xA5..A5; wr_cnt=1; wen_q=0 in the following cycle with wdata_q unchanged.
- Three back-to-back writes (adr 1,2,3) with array_hold=1 for 4 cycles -> wr_rdy drops after 2 accepts; wen_q=0 during hold; after release wen_q bits 1,2,3 on consecutive cycles, in order.
- Two writes to adr 0x10 (data 0x1 then 0x2) -> two consecutive wen_q[16] pulses with wdata_q 0x1 then 0x2.
- rd_adr=0x7F in the cycle wen_q[127]=1 -> byp_hit=1 and byp_data=wdata_q; same rd_adr one cycle later -> byp_hit=0.
- NUM_ENTRIES=200 build, write adr=0xC8 -> no wen_q bit set, err_oor pulses one cycle, wr_cnt unchanged.
- Assert rst_n=0 with count=2 mid-stream -> wen_q=0 and wr_cnt=0 immediately; after release, wr_rdy=1 and no stale write issues.

Source files
------------

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_pkg.sv
// Shared constants and request type for the 132b x 256 latch-array write stage.
package arf132b256e1r1w0cbbehcaa4acw_pkg;

    localparam int unsigned DWIDTH      = 132;
    localparam int unsigned NUM_ENTRIES = 256;
    localparam int unsigned ADR_W       = 8;

    typedef struct packed {
        logic [ADR_W-1:0]  adr;
        logic [DWIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_skid2.sv
// Two-entry valid/ready skid buffer of write requests; head is always slot 0.
module arf132b256e1r1w0cbbehcaa4acw_skid2
    import arf132b256e1r1w0cbbehcaa4acw_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_vld,
    output logic       in_rdy,
    input  wr_req_t    in_data,
    output logic       out_vld,
    input  logic       out_rdy,
    output wr_req_t    out_data,
    output logic [1:0] count
);

    logic [1:0] count_q;
    wr_req_t    slot_q [2];
    logic       push, pop, idx;

    assign in_rdy   = (count_q < 2'd2);
    assign out_vld  = (count_q != 2'd0);
    assign out_data = slot_q[0];
    assign count    = count_q;
    assign push     = in_vld & in_rdy;
    assign pop      = out_vld & out_rdy;
    // Slot index after an optional pop: only a lone held entry pushes into slot 1.
    assign idx      = (count_q == 2'd1) & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
        end else begin
            count_q <= count_q + 2'(push) - 2'(pop);
            if (pop)  slot_q[0]   <= slot_q[1];
            if (push) slot_q[idx] <= in_data;
        end
    end

    a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count_q <= 2'd2);

endmodule

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_wr_stage.sv
// Write-port front end: skid-buffered requests issued as a registered one-hot
// word enable plus data into the phase-B latches, with bypass and write count.
module arf132b256e1r1w0cbbehcaa4acw_wr_stage #(
    parameter int unsigned DWIDTH      = arf132b256e1r1w0cbbehcaa4acw_pkg::DWIDTH,
    parameter int unsigned NUM_ENTRIES = arf132b256e1r1w0cbbehcaa4acw_pkg::NUM_ENTRIES,
    parameter int unsigned ADR_W       = arf132b256e1r1w0cbbehcaa4acw_pkg::ADR_W,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_vld,
    output logic                   wr_rdy,
    input  logic [ADR_W-1:0]       wr_adr,
    input  logic [DWIDTH-1:0]      wr_data,
    input  logic                   array_hold,
    output logic [NUM_ENTRIES-1:0] wen_q,
    output logic [DWIDTH-1:0]      wdata_q,
    input  logic [ADR_W-1:0]       rd_adr,
    output logic                   byp_hit,
    output logic [DWIDTH-1:0]      byp_data,
    output logic                   err_oor,
    output logic [CNT_W-1:0]       wr_cnt
);
    import arf132b256e1r1w0cbbehcaa4acw_pkg::*;

    wr_req_t                in_req, head, iss_req;
    logic [1:0]             count;
    logic                   rdy_q, buf_rdy, buf_vld, in_range;
    logic                   acc, acc_ok, issue, push, pop;
    logic [ADR_W-1:0]       adr_q;
    logic                   err_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_ENTRIES-1:0] wen_d;

    if (NUM_ENTRIES >= (1 << ADR_W)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = (wr_adr < ADR_W'(NUM_ENTRIES));
    end

    assign in_req = '{adr: wr_adr, data: wr_data};
    // rdy_q holds ready low until the first edge after reset release.
    assign wr_rdy  = rdy_q & buf_rdy;
    assign acc     = wr_vld & wr_rdy;
    assign acc_ok  = acc & in_range;
    assign issue   = ~array_hold & (buf_vld | acc_ok);
    assign pop     = buf_vld & ~array_hold;
    assign push    = acc_ok & (buf_vld | array_hold);
    assign iss_req = buf_vld ? head : in_req;

    arf132b256e1r1w0cbbehcaa4acw_skid2 u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (push),
        .in_rdy   (buf_rdy),
        .in_data  (in_req),
        .out_vld  (buf_vld),
        .out_rdy  (pop),
        .out_data (head),
        .count    (count)
    );

    always_comb begin
        wen_d = '0;
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            wen_d[i] = issue & (iss_req.adr == ADR_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q   <= 1'b0;
            wen_q   <= '0;
            wdata_q <= '0;
            adr_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rdy_q <= 1'b1;
            wen_q <= wen_d;
            err_q <= acc & ~in_range;
            // Data holds on idle cycles so the latches see no toggles.
            if (issue) begin
                wdata_q <= iss_req.data;
                adr_q   <= iss_req.adr;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign byp_hit  = (|wen_q) & (rd_adr == adr_q);
    assign byp_data = wdata_q;
    assign err_oor  = err_q;
    assign wr_cnt   = cnt_q;

    a_wen_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(wen_q));
    a_count_le2:  assert property (@(posedge clk) disable iff (!rst_n) count <= 2'd2);
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_vld & ~wr_rdy) |=> ($stable(wr_adr) && $stable(wr_data)));

endmodule

// File: tb/tb_arf132b256e1r1w0cbbehcaa4acw_wr_stage.sv
// Directed bench with an issue-order scoreboard for the write stage.
module tb_arf132b256e1r1w0cbbehcaa4acw_wr_stage;
    import arf132b256e1r1w0cbbehcaa4acw_pkg::*;

    logic         clk, rst_n;
    logic         wr_vld, wr_rdy, array_hold, byp_hit, err_oor;
    logic [7:0]   wr_adr, rd_adr;
    logic [131:0] wr_data, wdata_q, byp_data;
    logic [255:0] wen_q;
    logic [15:0]  wr_cnt;

    logic         b_vld, b_rdy, b_hit, b_err;
    logic [7:0]   b_adr;
    logic [131:0] b_data, b_wdata, b_bdata;
    logic [199:0] b_wen;
    logic [15:0]  b_cnt;

    int errors = 0;
    int checks = 0;

    wr_req_t      sb [$];
    int           m_cnt = 0;
    logic         m_rdy = 1'b0;
    int           m_wcnt = 0;
    logic [255:0] one = 256'd1;
    logic [131:0] d_a5 = 132'({17{8'hA5}});
    logic [131:0] d_7f = 132'h3_DEAD_BEEF_0123_4567_89AB_CDEF_F00D;

    arf132b256e1r1w0cbbehcaa4acw_wr_stage dut (
        .clk (clk), .rst_n (rst_n), .wr_vld (wr_vld), .wr_rdy (wr_rdy), .wr_adr (wr_adr),
        .wr_data (wr_data), .array_hold (array_hold), .wen_q (wen_q), .wdata_q (wdata_q),
        .rd_adr (rd_adr), .byp_hit (byp_hit), .byp_data (byp_data), .err_oor (err_oor),
        .wr_cnt (wr_cnt)
    );

    arf132b256e1r1w0cbbehcaa4acw_wr_stage #(.NUM_ENTRIES (200)) dut200 (
        .clk (clk), .rst_n (rst_n), .wr_vld (b_vld), .wr_rdy (b_rdy), .wr_adr (b_adr),
        .wr_data (b_data), .array_hold (1'b0), .wen_q (b_wen), .wdata_q (b_wdata),
        .rd_adr (8'd0), .byp_hit (b_hit), .byp_data (b_bdata), .err_oor (b_err),
        .wr_cnt (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model acceptance/issue for the main DUT, then check after the edge.
    task automatic tick();
        logic    acc, iss;
        wr_req_t e;
        chk("wr_rdy", 256'(wr_rdy), 256'(m_rdy));
        acc = wr_vld && m_rdy;
        iss = ((m_cnt != 0) || acc) && !array_hold;
        if (acc) sb.push_back('{adr: wr_adr, data: wr_data});
        m_cnt = m_cnt + (acc ? 1 : 0) - (iss ? 1 : 0);
        if (iss && m_wcnt < 65535) m_wcnt++;
        @(posedge clk);
        #1;
        m_rdy = (m_cnt < 2);
        chk("wen_active", 256'(|wen_q), 256'(iss));
        chk("wr_cnt", 256'(wr_cnt), 256'(m_wcnt));
        if (iss && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_wen", wen_q, one << e.adr);
            chk("sb_wdata", 256'(wdata_q), 256'(e.data));
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [131:0] d);
        wr_vld  = v;
        wr_adr  = a;
        wr_data = d;
    endtask

    initial begin
        rst_n = 1'b0; array_hold = 1'b0; rd_adr = '0;
        drive(1'b0, 8'd0, '0);
        b_vld = 1'b0; b_adr = '0; b_data = '0;
        #12;
        chk("rst_wen", wen_q, '0);
        chk("rst_wdata", 256'(wdata_q), '0);
        chk("rst_cnt", 256'(wr_cnt), '0);
        chk("rst_err", 256'(err_oor), '0);
        chk("rst_rdy", 256'(wr_rdy), '0);
        rst_n = 1'b1;
        tick();

        // Single write, flow-through latency of one edge.
        drive(1'b1, 8'h05, d_a5);
        tick();
        drive(1'b0, 8'h00, '0);
        chk("single_wen", wen_q, one << 5);
        chk("single_data", 256'(wdata_q), 256'(d_a5));
        tick();
        chk("idle_wen", wen_q, '0);
        chk("idle_data_hold", 256'(wdata_q), 256'(d_a5));

        // Held array: two accepts fill the buffer, third waits.
        array_hold = 1'b1;
        drive(1'b1, 8'd1, 132'h111);
        tick();
        drive(1'b1, 8'd2, 132'h222);
        tick();
        drive(1'b1, 8'd3, 132'h333);
        tick();
        chk("hold_rdy_low", 256'(wr_rdy), '0);
        tick();
        array_hold = 1'b0;
        tick();
        chk("rel_wen1", wen_q, one << 1);
        tick();
        drive(1'b0, 8'd0, '0);
        chk("rel_wen2", wen_q, one << 2);
        tick();
        chk("rel_wen3", wen_q, one << 3);
        tick();

        // Same address twice: both issue, in order.
        drive(1'b1, 8'h10, 132'h1);
        tick();
        drive(1'b1, 8'h10, 132'h2);
        chk("waw_first", 256'(wdata_q), 256'd1);
        tick();
        drive(1'b0, 8'd0, '0);
        chk("waw_second_wen", wen_q, one << 16);
        chk("waw_second", 256'(wdata_q), 256'd2);
        tick();

        // Bypass on the issue cycle only.
        rd_adr = 8'h7F;
        drive(1'b1, 8'h7F, d_7f);
        tick();
        drive(1'b0, 8'd0, '0);
        chk("byp_hit", 256'(byp_hit), 256'd1);
        chk("byp_data", 256'(byp_data), 256'(d_7f));
        rd_adr = 8'h7E;
        #1;
        chk("byp_other_adr", 256'(byp_hit), '0);
        rd_adr = 8'h7F;
        tick();
        chk("byp_after", 256'(byp_hit), '0);

        // 200-entry build: last valid word, then out-of-range drop.
        b_vld = 1'b1; b_adr = 8'hC7; b_data = 132'hC7;
        tick();
        chk("b_wen199", 256'(b_wen), one << 199);
        chk("b_cnt1", 256'(b_cnt), 256'd1);
        b_adr = 8'hC8; b_data = 132'hC8;
        tick();
        b_vld = 1'b0;
        chk("oor_wen", 256'(b_wen), '0);
        chk("oor_err", 256'(b_err), 256'd1);
        chk("oor_cnt", 256'(b_cnt), 256'd1);
        tick();
        chk("oor_err_pulse", 256'(b_err), '0);
        chk("oor_rdy", 256'(b_rdy), 256'd1);

        // Reset with a full buffer discards both entries.
        array_hold = 1'b1;
        drive(1'b1, 8'h20, 132'hA);
        tick();
        drive(1'b1, 8'h21, 132'hB);
        tick();
        drive(1'b0, 8'd0, '0);
        chk("full_rdy", 256'(wr_rdy), '0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", wen_q, '0);
        chk("mid_rst_cnt", 256'(wr_cnt), '0);
        chk("mid_rst_rdy", 256'(wr_rdy), '0);
        sb.delete();
        m_cnt = 0; m_rdy = 1'b0; m_wcnt = 0;
        array_hold = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("no_stale", wen_q, '0);
        drive(1'b1, 8'h33, 132'h33);
        tick();
        drive(1'b0, 8'd0, '0);
        chk("post_rst_wen", wen_q, one << 8'h33);
        tick();
        chk("sb_empty", 256'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
